// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state encoding and captured-command record for the ALU op sequencer.
// Divide support in the sequencer is enabled by defining ALU_SEQ_DIV_EN.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_MLA  = 3'b100;
  localparam logic [2:0] OP_SDIV = 3'b101;
  localparam logic [2:0] OP_UDIV = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2,
    ERR  = 2'd3
  } state_e;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] rd;
    logic [3:0] rn;
    logic [3:0] rm;
    logic [3:0] ra;
  } cmd_t;

  function automatic logic is_div(input logic [2:0] op);
    return (op == OP_SDIV) || (op == OP_UDIV);
  endfunction

endpackage

// File: rtl/alu_seq_lat_cnt.sv
// Down-counter that times the EXEC phase: loaded with the op latency on accept,
// decremented every EXEC cycle, flagging the final EXEC cycle.
module alu_seq_lat_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         last_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle command sequencer driving an external register file / ALU datapath.
// Define ALU_SEQ_DIV_EN to support SDIV/UDIV; otherwise divides are rejected through ERR.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int MLA_LAT = 2,
  parameter int DIV_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [3:0]  cmd_rd,
  input  logic [3:0]  cmd_rn,
  input  logic [3:0]  cmd_rm,
  input  logic [3:0]  cmd_ra,
  output logic [3:0]  RA1,
  output logic [3:0]  RA2,
  output logic [3:0]  RA3,
  output logic [2:0]  ALUControl,
  output logic        MLA_Select,
  input  logic [31:0] RD2,
  input  logic [31:0] ALUResult,
  output logic [3:0]  WA,
  output logic [31:0] WD,
  output logic        RegWrite,
  output logic        done,
  output logic        err,
  output logic        busy
);

`ifdef ALU_SEQ_DIV_EN
  localparam int MAX_LAT = (MLA_LAT > DIV_LAT) ? MLA_LAT : DIV_LAT;
`else
  localparam int MAX_LAT = MLA_LAT;
`endif
  localparam int CW = $clog2(((MAX_LAT > 1) ? MAX_LAT : 1) + 1);

  state_e      state_q, state_d;
  cmd_t        cmd_q, cmd_d;
  logic [31:0] result_q, result_d;
  logic        op_ok;
  logic [CW-1:0] lat_val;
  logic        cnt_load;
  logic        cnt_last;
  logic        div_zero;

  // Only the first EXEC cycle of a divide may be turned into a divide-by-zero error.
`ifdef ALU_SEQ_DIV_EN
  logic first_q, first_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) first_q <= 1'b0;
    else        first_q <= first_d;
  end

  assign div_zero = first_q && is_div(cmd_q.op) && (RD2 == '0);
`else
  logic unused_div;
  assign unused_div = ^{RD2, DIV_LAT};
  assign div_zero   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    op_ok   = 1'b0;
    lat_val = '0;
    case (cmd_op)
      OP_ADD: begin op_ok = 1'b1; lat_val = CW'(1);       end
      OP_MLA: begin op_ok = 1'b1; lat_val = CW'(MLA_LAT); end
`ifdef ALU_SEQ_DIV_EN
      OP_SDIV, OP_UDIV: begin op_ok = 1'b1; lat_val = CW'(DIV_LAT); end
`endif
      default: ;
    endcase
  end

  alu_seq_lat_cnt #(.W(CW)) u_lat_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (lat_val),
    .dec_i      (state_q == EXEC),
    .last_o     (cnt_last)
  );

  // Datapath controls are decoded purely from registered state and the captured command.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    result_d   = result_q;
    cnt_load   = 1'b0;
`ifdef ALU_SEQ_DIV_EN
    first_d    = first_q;
`endif
    cmd_ready  = 1'b0;
    RA1        = '0;
    RA2        = '0;
    RA3        = '0;
    ALUControl = '0;
    MLA_Select = 1'b0;
    WA         = '0;
    WD         = '0;
    RegWrite   = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cmd_d = '{op: cmd_op, rd: cmd_rd, rn: cmd_rn, rm: cmd_rm, ra: cmd_ra};
          if (op_ok) begin
            state_d  = EXEC;
            cnt_load = 1'b1;
`ifdef ALU_SEQ_DIV_EN
            first_d  = 1'b1;
`endif
          end else begin
            state_d = ERR;
          end
        end
      end
      EXEC: begin
        RA1        = cmd_q.rn;
        RA2        = cmd_q.rm;
        RA3        = cmd_q.ra;
        ALUControl = cmd_q.op;
        MLA_Select = (cmd_q.op == OP_MLA);
`ifdef ALU_SEQ_DIV_EN
        first_d    = 1'b0;
`endif
        if (div_zero) begin
          state_d = ERR;
        end else if (cnt_last) begin
          result_d = ALUResult;
          state_d  = WB;
        end
      end
      WB: begin
        RegWrite = 1'b1;
        WA       = cmd_q.rd;
        WD       = result_q;
        done     = 1'b1;
        state_d  = IDLE;
      end
      ERR: begin
        err     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: a behavioural register-file/ALU model stands in
// for the datapath, and per-command predictions are derived from opcode latency rules.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int MLA_LAT = 2;
  localparam int DIV_LAT = 4;
`ifdef ALU_SEQ_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [3:0]  cmd_rd, cmd_rn, cmd_rm, cmd_ra;
  logic [3:0]  RA1, RA2, RA3;
  logic [2:0]  ALUControl;
  logic        MLA_Select;
  logic [31:0] RD2, ALUResult;
  logic [3:0]  WA;
  logic [31:0] WD;
  logic        RegWrite, done, err, busy;

  logic [31:0] dpRf [16];
  logic [31:0] modelRf [16];
  logic        preWe;
  logic [3:0]  preAddr;
  logic [31:0] preData;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct packed {
    int          accepted;
    int          doneCyc;
    int          errCyc;
    int          readyCyc;
    int          writes;
    int          mlaCyc;
    int          execBad;
    logic [3:0]  wa;
    logic [31:0] wd;
  } obs_t;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_op_sequencer #(.MLA_LAT(MLA_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm), .cmd_ra(cmd_ra),
    .RA1(RA1), .RA2(RA2), .RA3(RA3), .ALUControl(ALUControl), .MLA_Select(MLA_Select),
    .RD2(RD2), .ALUResult(ALUResult), .WA(WA), .WD(WD), .RegWrite(RegWrite),
    .done(done), .err(err), .busy(busy)
  );

  function automatic logic [31:0] aluRef(input logic [2:0] op, input logic [31:0] a, b, c);
    case (op)
      OP_ADD:  return a + b;
      OP_MLA:  return a * b + c;
      OP_UDIV: return (b == 0) ? 32'd0 : a / b;
      OP_SDIV: begin
        if (b == 0) return 32'd0;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'($signed(a) / $signed(b));
      end
      default: return 32'd0;
    endcase
  endfunction

  assign RD2       = dpRf[RA2];
  assign ALUResult = aluRef(ALUControl, dpRf[RA1], dpRf[RA2], dpRf[RA3]);

  always @(posedge clk) begin
    if (preWe)         dpRf[preAddr] <= preData;
    else if (RegWrite) dpRf[WA]      <= WD;
  end

  function automatic string fmtObs(input obs_t o);
    return $sformatf("acc=%0d done=%0d err=%0d ready=%0d wr=%0d wa=%0d wd=%h mla=%0d bad=%0d",
                     o.accepted, o.doneCyc, o.errCyc, o.readyCyc, o.writes, o.wa, o.wd, o.mlaCyc, o.execBad);
  endfunction

  task automatic preload(input logic [3:0] addr, input logic [31:0] data);
    @(negedge clk);
    preWe = 1'b1; preAddr = addr; preData = data;
    @(posedge clk); #1;
    preWe = 1'b0;
    modelRf[addr] = data;
  endtask

  // Reference model: outcome of one command from the latency/error rules and the model register file.
  task automatic predict(input logic [2:0] op, input logic [3:0] rd, rn, rm, ra, output obs_t e);
    int L;
    bit ok, isDiv;
    e = '0;
    e.accepted = 1; e.doneCyc = -1; e.errCyc = -1;
    isDiv = (op == OP_SDIV) || (op == OP_UDIV);
    ok = (op == OP_ADD) || (op == OP_MLA) || (DIV_ON && isDiv);
    L  = (op == OP_ADD) ? 1 : (op == OP_MLA) ? MLA_LAT : DIV_LAT;
    if (!ok) begin
      e.errCyc = 1; e.readyCyc = 2;
    end else if (isDiv && modelRf[rm] == 0) begin
      e.errCyc = 2; e.readyCyc = 3;
    end else begin
      e.doneCyc = L + 1; e.readyCyc = L + 2; e.writes = 1; e.wa = rd;
      e.wd = aluRef(op, modelRf[rn], modelRf[rm], modelRf[ra]);
      if (op == OP_MLA) e.mlaCyc = L;
      modelRf[rd] = e.wd;
    end
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [3:0] rd, rn, rm, ra, output obs_t g);
    g = '0;
    g.doneCyc = -1; g.errCyc = -1; g.readyCyc = -1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rn = rn; cmd_rm = rm; cmd_ra = ra;
    g.accepted = int'(cmd_ready);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (done)       g.doneCyc = (g.doneCyc < 0) ? cyc : -2;
      if (err)        g.errCyc  = (g.errCyc  < 0) ? cyc : -2;
      if (RegWrite)   begin g.writes++; g.wa = WA; g.wd = WD; end
      if (MLA_Select) g.mlaCyc++;
      if (busy && !RegWrite && !err && ({RA1, RA2, RA3, ALUControl} !== {rn, rm, ra, op})) g.execBad++;
      if (cmd_ready) begin g.readyCyc = cyc; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rn = '0; cmd_rm = '0; cmd_ra = '0;
    preWe = 1'b0; preAddr = '0; preData = '0;
    repeat (3) @(posedge clk);
    #1;
    assertCount++;
    if ({busy, RegWrite, done, err, MLA_Select, RA1, RA2, RA3, ALUControl, WA, WD} !== '0) begin
      failCount++;
      $display("[TB] FAIL reset_outputs: got busy=%b we=%b done=%b err=%b wa=%0d wd=%h ra1=%0d alu=%0d, expected all 0",
               busy, RegWrite, done, err, WA, WD, RA1, ALUControl);
    end
    assertCount++;
    if (cmd_ready !== 1'b1) begin failCount++; $display("[TB] FAIL reset_ready: got %b, expected 1", cmd_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    assertCount++;
    if ({cmd_ready, busy} !== 2'b10) begin failCount++; $display("[TB] FAIL post_reset_ready: got ready=%b busy=%b, expected 1/0", cmd_ready, busy); end
    for (int i = 0; i < 16; i++) preload(4'(i), $urandom_range(0, 1000));
  endtask

  task automatic test_directed();
    obs_t g, e;
    preload(4'd0, 32'd10); preload(4'd1, 32'd5); preload(4'd2, 32'd2); preload(4'd7, 32'd0);
    predict(OP_ADD, 4'd3, 4'd0, 4'd1, 4'd0, e);
    applyStimulus(OP_ADD, 4'd3, 4'd0, 4'd1, 4'd0, g);
    assertCount++;
    if (g !== e) begin failCount++; $display("[TB] FAIL add_basic: got %s, expected %s", fmtObs(g), fmtObs(e)); end
    assertCount++;
    if ({g.wa, g.wd, g.doneCyc} !== {4'd3, 32'd15, 32'd2}) begin failCount++; $display("[TB] FAIL add_const: got wa=%0d wd=%0d cyc=%0d, expected 3/15/2", g.wa, g.wd, g.doneCyc); end
    predict(OP_MLA, 4'd4, 4'd0, 4'd1, 4'd2, e);
    applyStimulus(OP_MLA, 4'd4, 4'd0, 4'd1, 4'd2, g);
    assertCount++;
    if (g !== e) begin failCount++; $display("[TB] FAIL mla_basic: got %s, expected %s", fmtObs(g), fmtObs(e)); end
    assertCount++;
    if ({g.wa, g.wd, g.doneCyc, g.mlaCyc} !== {4'd4, 32'd52, 32'd3, 32'd2}) begin failCount++; $display("[TB] FAIL mla_const: got wa=%0d wd=%0d cyc=%0d mla=%0d, expected 4/52/3/2", g.wa, g.wd, g.doneCyc, g.mlaCyc); end
    predict(OP_UDIV, 4'd5, 4'd0, 4'd1, 4'd0, e);
    applyStimulus(OP_UDIV, 4'd5, 4'd0, 4'd1, 4'd0, g);
    assertCount++;
    if (g !== e) begin failCount++; $display("[TB] FAIL udiv_basic: got %s, expected %s", fmtObs(g), fmtObs(e)); end
    predict(OP_SDIV, 4'd6, 4'd0, 4'd7, 4'd0, e);
    applyStimulus(OP_SDIV, 4'd6, 4'd0, 4'd7, 4'd0, g);
    assertCount++;
    if (g !== e) begin failCount++; $display("[TB] FAIL sdiv_by_zero: got %s, expected %s", fmtObs(g), fmtObs(e)); end
  endtask

  task automatic test_unsupported();
    obs_t g, e;
    logic [2:0] badOps [4] = '{3'b011, 3'b001, 3'b010, 3'b111};
    for (int i = 0; i < 4; i++) begin
      predict(badOps[i], 4'd11, 4'd1, 4'd2, 4'd0, e);
      applyStimulus(badOps[i], 4'd11, 4'd1, 4'd2, 4'd0, g);
      assertCount++;
      if (g !== e) begin failCount++; $display("[TB] FAIL unsupported_op%0b: got %s, expected %s", badOps[i], fmtObs(g), fmtObs(e)); end
    end
  endtask

  task automatic test_hold_valid();
    int nW = 0, early = 0, bad = 0, readyAt = -1;
    int wCyc [2] = '{-1, -1};
    logic [3:0]  wA [2] = '{4'd0, 4'd0};
    logic [31:0] wD [2] = '{32'd0, 32'd0};
    logic [31:0] mlaVal, addVal;
    mlaVal = modelRf[0] * modelRf[1] + modelRf[2];
    modelRf[9] = mlaVal;
    addVal = modelRf[1] + modelRf[2];
    modelRf[10] = addVal;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_MLA; cmd_rd = 4'd9; cmd_rn = 4'd0; cmd_rm = 4'd1; cmd_ra = 4'd2;
    @(posedge clk); #1;
    cmd_op = OP_ADD; cmd_rd = 4'd10; cmd_rn = 4'd1; cmd_rm = 4'd2; cmd_ra = 4'd0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (RegWrite) begin
        if (nW < 2) begin wCyc[nW] = cyc; wA[nW] = WA; wD[nW] = WD; end
        nW++;
      end
      if (cyc <= MLA_LAT && ({RA1, RA2, RA3, ALUControl} !== {4'd0, 4'd1, 4'd2, OP_MLA})) bad++;
      if (cmd_ready && cyc < MLA_LAT + 2) early++;
      if (cmd_ready && readyAt < 0) readyAt = cyc;
      @(posedge clk); #1;
      if (readyAt > 0) cmd_valid = 1'b0;
    end
    assertCount++;
    if ({nW, early, bad} !== {32'd2, 32'd0, 32'd0}) begin failCount++; $display("[TB] FAIL hold_valid_counts: got writes=%0d early=%0d bad=%0d, expected 2/0/0", nW, early, bad); end
    assertCount++;
    if ({wCyc[0], wA[0], wD[0]} !== {32'(MLA_LAT + 1), 4'd9, mlaVal}) begin failCount++; $display("[TB] FAIL hold_valid_first: got cyc=%0d wa=%0d wd=%h, expected %0d/9/%h", wCyc[0], wA[0], wD[0], MLA_LAT + 1, mlaVal); end
    assertCount++;
    if ({wCyc[1], wA[1], wD[1]} !== {32'(MLA_LAT + 4), 4'd10, addVal}) begin failCount++; $display("[TB] FAIL hold_valid_second: got cyc=%0d wa=%0d wd=%h, expected %0d/10/%h", wCyc[1], wA[1], wD[1], MLA_LAT + 4, addVal); end
  endtask

  task automatic test_reset_abort();
    obs_t g, e;
    int bad = 0;
    logic [2:0] longOp;
    longOp = DIV_ON ? OP_UDIV : OP_MLA;
    preload(4'd1, 32'd5);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = longOp; cmd_rd = 4'd8; cmd_rn = 4'd0; cmd_rm = 4'd1; cmd_ra = 4'd2;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    assertCount++;
    if ({busy, cmd_ready} !== 2'b01) begin failCount++; $display("[TB] FAIL abort_immediate: got busy=%b ready=%b, expected 0/1", busy, cmd_ready); end
    for (int i = 0; i < 8; i++) begin
      if (RegWrite || done || err) bad++;
      if (i == 1) rst_n = 1'b1;
      @(posedge clk); #1;
    end
    assertCount++;
    if ({bad, 31'd0, cmd_ready} !== {32'd0, 32'd1}) begin failCount++; $display("[TB] FAIL abort_quiet: got pulses=%0d ready=%b, expected 0/1", bad, cmd_ready); end
    predict(OP_ADD, 4'd12, 4'd0, 4'd1, 4'd0, e);
    applyStimulus(OP_ADD, 4'd12, 4'd0, 4'd1, 4'd0, g);
    assertCount++;
    if (g !== e) begin failCount++; $display("[TB] FAIL abort_then_add: got %s, expected %s", fmtObs(g), fmtObs(e)); end
  endtask

  task automatic test_random();
    obs_t g, e;
    logic [2:0] opPool [10] = '{OP_ADD, OP_MLA, OP_SDIV, OP_UDIV, OP_ADD, OP_MLA, OP_SDIV, OP_UDIV, 3'b011, 3'b111};
    logic [2:0] op;
    logic [3:0] rd, rn, rm, ra;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 0)
        preload(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
      op = opPool[$urandom_range(0, 9)];
      rd = 4'($urandom_range(0, 15)); rn = 4'($urandom_range(0, 15));
      rm = 4'($urandom_range(0, 15)); ra = 4'($urandom_range(0, 15));
      predict(op, rd, rn, rm, ra, e);
      applyStimulus(op, rd, rn, rm, ra, g);
      assertCount++;
      if (g !== e) begin failCount++; $display("[TB] FAIL random_%0d op=%b: got %s, expected %s", n, op, fmtObs(g), fmtObs(e)); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_unsupported();
    test_hold_valid();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
